// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle MIPS fetch path: pcsource codes,
// fetch state encoding, reset vector and an alignment helper.
package sc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ERR   = 2'b11
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/sc_ifetch_if.sv
// Instruction-memory request/ready channel between the fetch stage (master)
// and the instruction memory (slave).
interface sc_ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/sc_next_pc.sv
// Next-PC computation: sequential, branch, jr and j/jal targets with a 4:1
// select on pcsource. Purely combinational so the pipelined core can reuse it.
module sc_next_pc
  import sc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsource,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic [31:0] br_off_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;

  assign pc4         = pc + 32'd4;
  assign br_off_s    = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign br_target_s = pc4 + br_off_s;
  assign j_target_s  = {pc4[31:28], inst[25:0], 2'b00};

  // target select on the control unit's pcsource
  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PC_SEQ:  next_pc = pc4;
      PC_BR:   next_pc = br_target_s;
      PC_JR:   next_pc = rpc;
      PC_J:    next_pc = j_target_s;
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifetch.sv
// Fetch stage: holds the PC, fetches from variable-latency imem and presents
// the instruction to decode until commit, then steps to the selected next PC.
module sc_ifetch
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  sc_ifetch_if.master imem,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        commit,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rpc,
  output logic        fault
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  inst_r;
  logic         req_r;
  logic         valid_r;
  logic         fault_r;
  logic [31:0]  next_pc_s;

  sc_next_pc u_next_pc (
    .pc       (pc_r),
    .inst     (inst_r[25:0]),
    .rpc      (rpc),
    .pcsource (pcsource),
    .pc4      (pc4),
    .next_pc  (next_pc_s)
  );

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign inst           = inst_r;
  assign inst_valid     = valid_r;
  assign pc             = pc_r;
  assign fault          = fault_r;

  // fetch FSM with PC/instruction registers and registered handshake outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      inst_r  <= 32'h0000_0000;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            inst_r  <= imem.imem_rdata;
            state_r <= HOLD;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (commit) begin
            valid_r <= 1'b0;
            // a misaligned jr target leaves pc untouched and parks the stage
            if ((pcsource == PC_JR) && !word_aligned(rpc)) begin
              state_r <= ERR;
              fault_r <= 1'b1;
            end else begin
              pc_r    <= next_pc_s;
              state_r <= FETCH;
              req_r   <= 1'b1;
            end
          end
        end
        ERR: begin
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
        default: begin
          state_r <= ERR;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sc_ifetch.md
# sc_ifetch

Instruction-fetch stage for the single-cycle MIPS datapath, directly upstream of the control unit. Holds the PC and fetches instruction words from a variable-latency instruction memory over a req/ready handshake. Presents each instruction, with its op/func fields, to decode and the control unit until downstream signals commit. On commit, selects the next PC from the control unit's `pcsource`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clock`  in  1: single clock; rising edge.
- `resetn`  in  1: asynchronous active-low reset.
- `imem_req`  out  1: fetch request; held until accepted.
- `imem_addr`  out  32: fetch address; equals `pc`.
- `imem_ready`  in  1: memory response valid this cycle.
- `imem_rdata`  in  32: instruction word; valid when `imem_ready` is high.
- `inst`  out  32: held instruction; `inst[31:26]` is op and `inst[5:0]` is func, feeding the control unit.
- `inst_valid`  out  1: `inst` is valid and awaiting commit.
- `pc`  out  32: address of the current instruction.
- `pc4`  out  32: `pc` + 4, for jal link.
- `commit`  in  1: downstream has executed `inst`; `pcsource` and `rpc` are valid this cycle.
- `pcsource`  in  2: 00 = pc4; 01 = branch; 10 = jr; 11 = j/jal.
- `rpc`  in  32: jr target (rs register value).
- `fault`  out  1: sticky misaligned-jr error.

## Operation
- States: IDLE, FETCH, HOLD, ERR.
- Reset (async, immediate):
  - state = IDLE, `pc` = RESET_PC, `inst` = 0.
  - `imem_req` = 0, `inst_valid` = 0, `fault` = 0.
- IDLE -> FETCH on the first rising edge with `resetn` high.
- FETCH:
  - `imem_req` = 1, `imem_addr` = `pc`.
  - When `imem_ready` = 1 at an edge: `inst` <= `imem_rdata`, go to HOLD.
  - `commit` is ignored.
- HOLD:
  - `inst_valid` = 1, `imem_req` = 0.
  - When `commit` = 1 at an edge: `pc` <= next PC, go to FETCH.
  - `imem_ready` is ignored.
- Next-PC arithmetic, all modulo 2^32:
  - pc4 = pc + 4.
  - Branch = pc4 + ({{14{inst[15]}}, inst[15:0], 2'b00}).
  - Jump = {pc4[31:28], inst[25:0], 2'b00}.
  - jr = `rpc`.
- Commit with `pcsource` = 10 and `rpc[1:0]` != 0:
  - `pc` is unchanged; go to ERR and set `fault` = 1.
- ERR:
  - `imem_req` = 0, `inst_valid` = 0.
  - Left only by reset.
- `imem_ready` in IDLE or ERR is ignored; no state change.

## Timing
- All outputs are registered, or decoded only from state and registers; there are no combinational input-to-output paths.
- First `imem_req` is asserted one cycle after the first edge with `resetn` high.
- `inst_valid` rises the cycle after the edge that samples `imem_ready`.
- Minimum instruction period is 2 cycles (zero-wait memory): FETCH then HOLD.
- After a commit edge, `imem_req` = 1 with the new address in the following cycle.
- `imem_addr` is stable for the whole time `imem_req` is high.
- Reset mid-fetch:
  - `imem_req` drops asynchronously.
  - The memory must discard the pending response.
  - A late `imem_ready` is ignored.
- PC wrap: `pc` = 0xFFFFFFFC with `pcsource` 00 gives next `pc` = 0x00000000.

## Structure
- Shared package `sc_pkg`:
  - pcsource encodings PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JR = 2'b10, PC_J = 2'b11.
  - Fetch state encoding.
  - Reset-vector default.
- Sub-module `sc_next_pc`: combinational target computation and 4:1 mux, taking `pc`, `inst`, `rpc` and `pcsource`. It is reused by the pipelined variant.
- `sc_ifetch` itself contains the state machine, PC register and instruction register.

## Test plan
- Reset, RESET_PC = 0x00400000:
  - While `resetn` = 0: `imem_req` = 0, `inst_valid` = 0, `fault` = 0.
  - After release: one cycle later `imem_req` = 1 and `imem_addr` = 0x00400000.
- Sequential fetch, `imem_ready` after 3 wait cycles with `imem_rdata` = 0x20080005:
  - `inst_valid` = 1 and `inst` = 0x20080005 one cycle after ready.
  - Commit with `pcsource` 00: next `imem_addr` = 0x00400004.
- Branch: `pc` = 0x00400010, `inst` = 0x1109FFFE (beq, imm -2), commit with `pcsource` 01 -> next `imem_addr` = 0x0040000C.
- Jump: `pc` = 0x00400020, `inst` = 0x0C100000, commit with `pcsource` 11 -> `imem_addr` = 0x00400000 and `pc4` = 0x00400024 during HOLD.
- jr:
  - `rpc` = 0x00400100 with `pcsource` 10 -> fetch at 0x00400100.
  - `rpc` = 0x00400102 -> `fault` = 1; `imem_req` and `inst_valid` stay 0 until reset.
- Reset and ignore cases:
  - Assert `resetn` low while FETCH waits; pulse `imem_ready` during reset -> no `inst` load.
  - Refetch from RESET_PC after release.
  - Commit pulsed during FETCH -> ignored.
  - `pc` = 0xFFFFFFFC with commit 00 -> `imem_addr` = 0.
